// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Shares NUM_WRITE register-file write ports between NUM_REQ
//                valid/ready writeback requesters. Requests are granted in
//                round-robin order, and two writes to the same address are
//                never granted in one cycle. Grants are registered onto
//                WE/WADDR/WDATA. CONFLICT_CNT saturates and counts the cycles
//                in which a valid request was deferred.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int NUM_REQ   = 4,
    parameter int NUM_WRITE = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      STALL,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    input  logic [AW*NUM_REQ-1:0]     REQ_ADDR,
    input  logic [DW*NUM_REQ-1:0]     REQ_DATA,
    output logic [NUM_REQ-1:0]        REQ_READY,
    output logic [NUM_WRITE-1:0]      WE,
    output logic [AW*NUM_WRITE-1:0]   WADDR,
    output logic [DW*NUM_WRITE-1:0]   WDATA,
    output logic [15:0]               CONFLICT_CNT
);

    // Pointer width. NUM_REQ >= 2 keeps this at 1 bit or more.
    localparam int PW = $clog2(NUM_REQ);
    // The grant counter has to hold the value NUM_WRITE.
    localparam int CW = $clog2(NUM_WRITE + 1);

    localparam logic [PW:0]   c_NUM_REQ  = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0] c_LAST_REQ = PW'(NUM_REQ - 1);
    localparam logic [CW-1:0] c_NUM_WR   = CW'(NUM_WRITE);

    logic [PW-1:0]                  r_ptr;
    logic [NUM_WRITE-1:0]           r_we;
    logic [NUM_WRITE-1:0][AW-1:0]   r_waddr;
    logic [NUM_WRITE-1:0][DW-1:0]   r_wdata;
    logic [15:0]                    r_cnt;

    logic [NUM_REQ-1:0]             w_ready;
    logic [NUM_WRITE-1:0]           w_pwe;
    logic [NUM_WRITE-1:0][AW-1:0]   w_paddr;
    logic [NUM_WRITE-1:0][DW-1:0]   w_pdata;
    logic [CW-1:0]                  w_gcnt;
    logic [PW-1:0]                  w_last;
    logic [PW-1:0]                  w_ptr_nxt;
    logic                           w_defer;

    // Scan from r_ptr. Each valid request takes the next free port unless
    // that would repeat an address already granted in this cycle.
    always_comb begin : p_grant
        logic [PW:0]   w_sum;
        logic          w_v;
        logic [AW-1:0] w_a;
        logic [DW-1:0] w_d;
        logic          w_hit;

        w_ready = '0;
        w_pwe   = '0;
        w_paddr = '0;
        w_pdata = '0;
        w_gcnt  = '0;
        w_last  = '0;
        w_sum   = '0;
        w_v     = 1'b0;
        w_a     = '0;
        w_d     = '0;
        w_hit   = 1'b0;

        for (int j = 0; j < NUM_REQ; j++) begin
            // Scan slot j selects requester (r_ptr + j) mod NUM_REQ.
            w_sum = {1'b0, r_ptr} + (PW+1)'(j);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end

            w_v = 1'b0;
            w_a = '0;
            w_d = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_sum == (PW+1)'(i)) begin
                    w_v = REQ_VALID[i];
                    w_a = REQ_ADDR[i*AW +: AW];
                    w_d = REQ_DATA[i*DW +: DW];
                end
            end

            // Check the address against the ports already granted this cycle.
            w_hit = 1'b0;
            for (int k = 0; k < NUM_WRITE; k++) begin
                if ((CW'(k) < w_gcnt) && (w_paddr[k] == w_a)) begin
                    w_hit = 1'b1;
                end
            end

            if (w_v && !STALL && RST && (w_gcnt < c_NUM_WR) && !w_hit) begin
                for (int k = 0; k < NUM_WRITE; k++) begin
                    if (w_gcnt == CW'(k)) begin
                        w_pwe[k]   = 1'b1;
                        w_paddr[k] = w_a;
                        w_pdata[k] = w_d;
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (w_sum == (PW+1)'(i)) begin
                        w_ready[i] = 1'b1;
                    end
                end
                w_gcnt = w_gcnt + CW'(1);
                w_last = w_sum[PW-1:0];
            end
        end
    end

    // Next pointer: the requester just after the last one granted, wrapping modulo NUM_REQ.
    always_comb begin
        w_ptr_nxt = (w_last == c_LAST_REQ) ? '0 : (w_last + PW'(1));
        w_defer   = |(REQ_VALID & ~w_ready);
    end

    // Register the grants into the write ports and update the pointer and the conflict counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_we    <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_we <= w_pwe;
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (w_pwe[k]) begin
                    r_waddr[k] <= w_paddr[k];
                    r_wdata[k] <= w_pdata[k];
                end
            end
            if (|w_pwe) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_defer && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign REQ_READY    = w_ready;
    assign WE           = r_we;
    assign WADDR        = r_waddr;
    assign WDATA        = r_wdata;
    assign CONFLICT_CNT = r_cnt;

endmodule
`default_nettype wire
